// File: rtl/ps2_key_display_ctrl.sv
// rtl/ps2_key_display_ctrl.sv - PS/2 scan-code sequencer feeding the hex seven-segment display
// Pops one FIFO byte per two clocks, decodes E0/F0 prefixes, holds the key and counts presses.
module ps2_key_display_ctrl #(
    parameter logic [7:0] BREAK_CODE  = 8'hF0,
    parameter logic [7:0] EXT_CODE    = 8'hE0,
    parameter logic [7:0] CNT_MAX_BCD = 8'h99
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_ready,
    input  logic [7:0] i_data,
    input  logic       i_overflow,
    output logic       o_nextdata_n,
    output logic [7:0] o_code,
    output logic [7:0] o_cnt,
    output logic       o_ext,
    output logic       o_key_down,
    output logic [3:0] o_blank,
    output logic       o_ovf_seen
);

    typedef enum logic {IDLE = 1'b0, PROC = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_r, byte_nxt;
    logic       brk, brk_nxt;
    logic       ext, ext_nxt;
    logic       nextdata_n_nxt;
    logic [7:0] code_nxt;
    logic [7:0] cnt_nxt;
    logic       o_ext_nxt;
    logic       key_down_nxt;
    logic [3:0] blank_nxt;
    logic       ovf_seen_nxt;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == CNT_MAX_BCD) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_ready) state_nxt = PROC;
            PROC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_nxt       = byte_r;
        brk_nxt        = brk;
        ext_nxt        = ext;
        nextdata_n_nxt = o_nextdata_n;
        code_nxt       = o_code;
        cnt_nxt        = o_cnt;
        o_ext_nxt      = o_ext;
        key_down_nxt   = o_key_down;
        blank_nxt      = o_blank;
        ovf_seen_nxt   = o_ovf_seen;

        case (state)
            IDLE: begin
                if (i_ready) begin
                    byte_nxt       = i_data;
                    nextdata_n_nxt = 1'b0;
                end
            end
            PROC: begin
                nextdata_n_nxt = 1'b1;
                if (byte_r == EXT_CODE) begin
                    ext_nxt = 1'b1;
                end else if (byte_r == BREAK_CODE) begin
                    brk_nxt = 1'b1;
                end else if (brk) begin
                    if (o_key_down && byte_r == o_code) begin
                        key_down_nxt = 1'b0;
                        o_ext_nxt    = 1'b0;
                    end
                    brk_nxt = 1'b0;
                    ext_nxt = 1'b0;
                end else begin
                    // Typematic repeats of the held code must not bump the count.
                    if (!o_key_down || byte_r != o_code) begin
                        code_nxt     = byte_r;
                        o_ext_nxt    = ext;
                        key_down_nxt = 1'b1;
                        cnt_nxt      = bcd_inc(o_cnt);
                    end
                    ext_nxt = 1'b0;
                end
            end
            default: nextdata_n_nxt = 1'b1;
        endcase

        // An overflow means the byte stream is broken: drop any partial prefix and this
        // cycle's decode, but leave the held key as it was.
        if (i_overflow) begin
            ovf_seen_nxt = 1'b1;
            brk_nxt      = 1'b0;
            ext_nxt      = 1'b0;
            code_nxt     = o_code;
            cnt_nxt      = o_cnt;
            o_ext_nxt    = o_ext;
            key_down_nxt = o_key_down;
        end

        // Blank flags keep their reset pattern until the first byte is decoded.
        if (state == PROC) begin
            blank_nxt = {(cnt_nxt[7:4] == 4'd0), 1'b0, {2{~key_down_nxt}}};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_r       <= 8'h00;
            brk          <= 1'b0;
            ext          <= 1'b0;
            o_nextdata_n <= 1'b1;
            o_code       <= 8'h00;
            o_cnt        <= 8'h00;
            o_ext        <= 1'b0;
            o_key_down   <= 1'b0;
            o_blank      <= 4'b0011;
            o_ovf_seen   <= 1'b0;
        end else begin
            byte_r       <= byte_nxt;
            brk          <= brk_nxt;
            ext          <= ext_nxt;
            o_nextdata_n <= nextdata_n_nxt;
            o_code       <= code_nxt;
            o_cnt        <= cnt_nxt;
            o_ext        <= o_ext_nxt;
            o_key_down   <= key_down_nxt;
            o_blank      <= blank_nxt;
            o_ovf_seen   <= ovf_seen_nxt;
        end
    end

endmodule
